// File: rtl/sha256_pkg.sv
// SHA-256 constants, work-block padding words, round/schedule helpers and the
// verifier FSM state encoding shared by the golden nonce verifier.
package sha256_pkg;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Pass 1 starts from an all-zero state; pass 2 from the standard IV (word a in [31:0]).
    localparam logic [255:0] IV_PASS1 = 256'd0;
    localparam logic [255:0] IV_PASS2 =
        256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667;

    // Upper block words: pass 1 covers W4..W15, pass 2 covers W8..W15.
    localparam logic [383:0] PAD_PASS1 = {32'h00000280, 320'd0, 32'h80000000};
    localparam logic [255:0] PAD_PASS2 = {32'h00000100, 192'd0, 32'h80000000};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_F1   = 3'd2,
        S_P2   = 3'd3,
        S_F2   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Word-wise modular sum; carries never cross a 32-bit boundary.
    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression datapath: one round and one message-schedule
// step per cycle that step is high; load seeds the state and 16-word window.
module sha256_iter_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [255:0] init_state,
    input  logic [511:0] init_block,
    input  logic         step,
    input  logic [5:0]   round_idx,
    output logic [255:0] state_out
);

    logic [255:0] st_q;
    logic [511:0] w_q;
    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [31:0]  t1, t2, new_w;

    always_comb begin
        a = st_q[31:0];
        b = st_q[63:32];
        c = st_q[95:64];
        d = st_q[127:96];
        e = st_q[159:128];
        f = st_q[191:160];
        g = st_q[223:192];
        h = st_q[255:224];
        t1 = h + big_sigma1(e) + ch(e, f, g) + w_q[31:0] + K[round_idx];
        t2 = big_sigma0(a) + maj(a, b, c);
        // W14, W9, W1, W0 of the current window produce the word 16 ahead.
        new_w = small_sigma1(w_q[479:448]) + w_q[319:288] + small_sigma0(w_q[63:32]) + w_q[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= '0;
            w_q  <= '0;
        end else if (load) begin
            st_q <= init_state;
            w_q  <= init_block;
        end else if (step) begin
            st_q <= {g, f, e, d + t1, c, b, a, t1 + t2};
            w_q  <= {new_w, w_q[511:32]};
        end
    end

    assign state_out = st_q;

endmodule

// File: rtl/golden_nonce_verifier.sv
// Recomputes the double SHA-256 of a candidate nonce's work block one round per
// clock and reports whether the leading DIFFICULTY bits of hash2 are zero.
module golden_nonce_verifier
    import sha256_pkg::*;
#(
    parameter int DIFFICULTY = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_nonce,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_pass,
    output logic [31:0]  out_nonce,
    output logic [255:0] out_hash,
    output logic [2:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; out_* stay frozen while out_valid waits for out_ready, and
    // in_ready is high only while idle, so the two handshakes never coincide.

    state_t       state;
    logic [5:0]   round_cnt;
    logic [31:0]  nonce_q;
    logic         accept;
    logic         core_load;
    logic         core_step;
    logic [255:0] core_init_state;
    logic [511:0] core_init_block;
    logic [255:0] core_state;
    logic [255:0] hash1;
    logic [255:0] hash2;
    logic         difficulty_met;

    always_comb begin
        accept          = (state == S_IDLE) && in_valid && in_ready;
        core_load       = accept || (state == S_F1);
        core_step       = (state == S_P1) || (state == S_P2);
        core_init_state = IV_PASS1;
        core_init_block = {PAD_PASS1, in_nonce, 96'd0};
        if (state == S_F1) begin
            core_init_state = IV_PASS2;
            core_init_block = {PAD_PASS2, hash1};
        end
    end

    sha256_iter_core u_core (
        .clk        (clk),
        .rst        (rst),
        .load       (core_load),
        .init_state (core_init_state),
        .init_block (core_init_block),
        .step       (core_step),
        .round_idx  (round_cnt),
        .state_out  (core_state)
    );

    assign hash1          = add_words(IV_PASS1, core_state);
    assign hash2          = add_words(IV_PASS2, core_state);
    assign difficulty_met = ~|hash2[255:256-DIFFICULTY];
    assign dbg_state      = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            round_cnt <= '0;
            nonce_q   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_pass  <= 1'b0;
            out_nonce <= '0;
            out_hash  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        nonce_q   <= in_nonce;
                        round_cnt <= '0;
                        in_ready  <= 1'b0;
                        state     <= S_P1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_P1: begin
                    round_cnt <= round_cnt + 6'd1;
                    if (round_cnt == 6'd63) state <= S_F1;
                end
                S_F1: begin
                    round_cnt <= '0;
                    state     <= S_P2;
                end
                S_P2: begin
                    round_cnt <= round_cnt + 6'd1;
                    if (round_cnt == 6'd63) state <= S_F2;
                end
                S_F2: begin
                    out_hash  <= hash2;
                    out_pass  <= difficulty_met;
                    out_nonce <= nonce_q;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
